// File: rtl/flash_read_cache_pkg.sv
// Shared types for the flash read cache: FSM state encoding and data width.
package flash_read_cache_pkg;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        CACHE_IDLE = 2'd0,
        CACHE_FILL = 2'd1,
        CACHE_RESP = 2'd2
    } cache_state_e;
endpackage

// File: rtl/flash_read_cache_if.sv
// Word read bus: valid held until a single-cycle ready strobe carrying rdata.
interface flash_read_cache_if #(parameter int ADDR_WIDTH = 24);
    import flash_read_cache_pkg::*;
    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_W-1:0]     rdata;

    modport master (output valid, addr, input ready, rdata);
    modport slave  (input valid, addr, output ready, rdata);
endinterface

// File: rtl/flash_read_cache_store.sv
// Data/tag arrays (async read, sync write) plus line-valid vector with one-cycle clear.
module flash_cache_store
    import flash_read_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 18
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              we,
    input  logic              set_vld,
    input  logic [IDX_W-1:0]  widx,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [TAG_W-1:0]  rtag,
    output logic [DATA_W-1:0] rdata,
    output logic              rvld
);
    logic [LINES-1:0][DATA_W-1:0] data_q;
    logic [LINES-1:0][TAG_W-1:0]  tag_q;
    logic [LINES-1:0]             vld_q;

    always_ff @(posedge clk) begin
        if (we) begin
            data_q[widx] <= wdata;
            tag_q[widx]  <= wtag;
        end
    end

    // Clear beats a same-cycle fill so a flush is never undone by a late line write.
    always_ff @(posedge clk) begin
        if (!resetn)             vld_q       <= '0;
        else if (clr)            vld_q       <= '0;
        else if (we && set_vld)  vld_q[widx] <= 1'b1;
    end

    assign rtag  = tag_q[ridx];
    assign rdata = data_q[ridx];
    assign rvld  = vld_q[ridx];
endmodule

// File: rtl/flash_read_cache.sv
// Direct-mapped, one-word-per-line read cache in front of spimemio.
// Optional FLASH_CACHE_STATS_EN adds hit/miss counters.
module flash_read_cache
    import flash_read_cache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    flash_read_cache_if.slave   core,
    flash_read_cache_if.master  mem
`ifdef FLASH_CACHE_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

    cache_state_e            state_q;
    logic                    ready_q, mem_valid_q, flush_seen_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag, s_tag;
    logic [DATA_W-1:0] s_rdata;
    logic              s_vld, hit, fill_we, unused_lsb;

    assign idx        = core.addr[IDX_W+1:2];
    assign tag        = core.addr[ADDR_WIDTH-1:IDX_W+2];
    assign unused_lsb = ^core.addr[1:0];
    assign hit        = s_vld && (s_tag == tag);
    assign fill_we    = (state_q == CACHE_FILL) && mem.ready;

    // Line index/tag for the fill come from the held mem_addr, not the core bus,
    // so a core that drops valid mid-fill still gets the right line written.
    flash_cache_store #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_store (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (flush),
        .we      (fill_we),
        .set_vld (!(flush_seen_q || flush)),
        .widx    (mem_addr_q[IDX_W+1:2]),
        .wtag    (mem_addr_q[ADDR_WIDTH-1:IDX_W+2]),
        .wdata   (mem.rdata),
        .ridx    (idx),
        .rtag    (s_tag),
        .rdata   (s_rdata),
        .rvld    (s_vld)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= CACHE_IDLE;
            ready_q      <= 1'b0;
            mem_valid_q  <= 1'b0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            case (state_q)
                CACHE_IDLE: begin
                    ready_q <= 1'b0;
                    if (!flush && core.valid) begin
                        if (hit) begin
                            rdata_q <= s_rdata;
                            ready_q <= 1'b1;
                            state_q <= CACHE_RESP;
                        end else begin
                            mem_valid_q  <= 1'b1;
                            mem_addr_q   <= {tag, idx, 2'b00};
                            flush_seen_q <= 1'b0;
                            state_q      <= CACHE_FILL;
                        end
                    end
                end
                CACHE_FILL: begin
                    if (flush) flush_seen_q <= 1'b1;
                    if (mem.ready) begin
                        mem_valid_q <= 1'b0;
                        rdata_q     <= mem.rdata;
                        ready_q     <= 1'b1;
                        state_q     <= CACHE_RESP;
                    end
                end
                CACHE_RESP: begin
                    ready_q <= 1'b0;
                    state_q <= CACHE_IDLE;
                end
                default: state_q <= CACHE_IDLE;
            endcase
        end
    end

`ifdef FLASH_CACHE_STATS_EN
    logic decide;
    assign decide = (state_q == CACHE_IDLE) && !flush && core.valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (decide) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

    assign core.ready = ready_q;
    assign core.rdata = rdata_q;
    assign mem.valid  = mem_valid_q;
    assign mem.addr   = mem_addr_q;
endmodule
